// File: rtl/mvm_result_buffer.sv
// Requantizing result buffer for the MVM engine.
// Captures a K-element frame of 2*B-bit signed results after done_in,
// shifts and saturates each element to B bits, tracks the argmax of the
// raw values, then presents the frame on a valid/ready stream.
module mvm_result_buffer #(
  parameter int K     = 32,
  parameter int B     = 8,
  parameter int SHIFT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      done_in,
  input  logic signed [2*B-1:0]     data_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [B-1:0]       out_data,
  output logic                      out_last,
  output logic [$clog2(K)-1:0]      argmax,
  output logic                      argmax_valid,
  output logic                      busy,
  output logic                      overflow,
  output logic                      dropped
);

  localparam int DATA_W = 2 * B;
  localparam int IW     = $clog2(K);
  localparam logic [IW-1:0] LAST = IW'(K - 1);
  localparam logic signed [DATA_W-1:0] SAT_HI = DATA_W'((1 << (B - 1)) - 1);
  localparam logic signed [DATA_W-1:0] SAT_LO = -SAT_HI - DATA_W'(1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t state, state_nxt;

  logic [IW-1:0]             wr_idx, rd_idx;
  logic                      done_p1;
  logic                      done_rise;
  logic                      take_max;
  logic signed [DATA_W-1:0]  run_max_p1;
  logic [IW-1:0]             run_idx_p1;
  logic signed [B-1:0]       mem [K];

  // Floor shift followed by clamp to the B-bit signed range.
  function automatic logic signed [B-1:0] requant(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] s;
    s = x >>> SHIFT;
    if (s > SAT_HI)      return SAT_HI[B-1:0];
    else if (s < SAT_LO) return SAT_LO[B-1:0];
    else                 return s[B-1:0];
  endfunction

  // True when requant would clamp the value.
  function automatic logic needs_sat(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] s;
    s = x >>> SHIFT;
    return (s > SAT_HI) || (s < SAT_LO);
  endfunction

  assign done_rise = done_in && !done_p1;
  // Element 0 always seeds the running max; later ones need strict greater-than.
  assign take_max  = (wr_idx == '0) || (data_in > run_max_p1);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and stream outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      IDLE: begin
        if (done_in) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        if (wr_idx == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (rd_idx == LAST);
        out_data  = mem[rd_idx];
        if (out_ready && rd_idx == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control: indices, edge detect, argmax result and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_idx       <= '0;
      rd_idx       <= '0;
      done_p1      <= 1'b0;
      argmax       <= '0;
      argmax_valid <= 1'b0;
      overflow     <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      done_p1 <= done_in;
      if (done_rise && state != IDLE) dropped <= 1'b1;
      case (state)
        IDLE: begin
          if (done_in) begin
            wr_idx       <= '0;
            argmax_valid <= 1'b0;
          end
        end
        CAPTURE: begin
          if (needs_sat(data_in)) overflow <= 1'b1;
          if (wr_idx == LAST) begin
            wr_idx       <= '0;
            rd_idx       <= '0;
            argmax       <= take_max ? wr_idx : run_idx_p1;
            argmax_valid <= 1'b1;
          end else begin
            wr_idx <= wr_idx + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Running maximum of the raw frame values.
  always_ff @(posedge clk) begin
    if (state == CAPTURE && take_max) begin
      run_max_p1 <= data_in;
      run_idx_p1 <= wr_idx;
    end
  end

  // Requantized element storage.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) mem[wr_idx] <= requant(data_in);
  end

endmodule

// File: tb/tb_mvm_result_buffer.sv
// Randomized bench for mvm_result_buffer against a frame-level reference model.
module tb_mvm_result_buffer;

  localparam int K     = 32;
  localparam int B     = 8;
  localparam int SHIFT = 4;
  localparam int IW    = $clog2(K);

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   done_in = 1'b0;
  logic signed [2*B-1:0]  data_in = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic signed [B-1:0]    out_data;
  logic                   out_last;
  logic [IW-1:0]          argmax;
  logic                   argmax_valid;
  logic                   busy;
  logic                   overflow;
  logic                   dropped;

  mvm_result_buffer #(.K(K), .B(B), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .done_in(done_in), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .argmax(argmax), .argmax_valid(argmax_valid),
    .busy(busy), .overflow(overflow), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int  fr [K];
  int  exp_q [K];
  int  exp_arg;
  bit  m_ovf  = 0;
  bit  m_drop = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Floor division by 2^SHIFT, then clamp to B-bit signed range.
  function automatic int ref_q(input int x, output bit clamped);
    int d, q, hi, lo;
    d  = 1 << SHIFT;
    hi = (1 << (B - 1)) - 1;
    lo = -(1 << (B - 1));
    q  = x / d;
    if (x < 0 && q * d != x) q = q - 1;
    clamped = 0;
    if (q > hi) begin q = hi; clamped = 1; end
    if (q < lo) begin q = lo; clamped = 1; end
    return q;
  endfunction

  task automatic build_model();
    bit c;
    int best;
    best = fr[0];
    exp_arg = 0;
    for (int n = 0; n < K; n++) begin
      exp_q[n] = ref_q(fr[n], c);
      if (c) m_ovf = 1;
      if (fr[n] > best) begin best = fr[n]; exp_arg = n; end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_argmax"}, argmax, 0);
    chk({tag, "_amv"}, argmax_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_drop"}, dropped, 0);
  endtask

  // ready_mode: 0 always, 1 pattern 1,0,0, 2 random, 3 mostly stalled.
  task automatic run_frame(input int ready_mode, input bit repulse, input int rst_at);
    int idx, cyc, budget;
    bit acc, pulsed;
    build_model();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk("cap_amv_clear", argmax_valid, 0);
    for (int n = 0; n < K; n++) begin
      chk("cap_busy", busy, 1);
      chk("cap_no_valid", out_valid, 0);
      done_in = repulse && (n == 10);
      data_in = 16'(fr[n]);
      tick();
    end
    done_in = 1'b0;
    data_in = 16'($urandom);
    chk("lat_first_valid", out_valid, 1);
    chk("drain_argmax", argmax, exp_arg);
    chk("drain_amv", argmax_valid, 1);
    idx = 0; cyc = 0; budget = 40 * K; pulsed = 0;
    while (idx < K && cyc < budget) begin
      if (idx == rst_at) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_ovf = 0; m_drop = 0;
        chk_reset_outputs("rst_mid_drain");
        return;
      end
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 3 == 0);
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = ($urandom_range(0, 3) == 0);
      endcase
      if (repulse && idx == 5 && !pulsed) begin done_in = 1'b1; pulsed = 1; end
      else done_in = 1'b0;
      chk("drain_valid", out_valid, 1);
      chk($sformatf("drain_data[%0d]", idx), out_data, exp_q[idx]);
      chk("drain_last", out_last, (idx == K - 1));
      acc = out_ready;
      tick();
      cyc++;
      if (acc) idx++;
    end
    done_in = 1'b0;
    out_ready = 1'b0;
    if (repulse) m_drop = 1;
    chk("drain_count", idx, K);
    chk("post_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_argmax", argmax, exp_arg);
    chk("post_amv", argmax_valid, 1);
    chk("post_ovf", overflow, m_ovf);
    chk("post_drop", dropped, m_drop);
  endtask

  task automatic idle_gap();
    int g;
    g = $urandom_range(1, 3);
    for (int i = 0; i < g; i++) tick();
  endtask

  task automatic rand_fill();
    bit wide;
    wide = ($urandom_range(0, 2) == 0);
    for (int n = 0; n < K; n++)
      fr[n] = wide ? int'($urandom_range(0, 65535)) - 32768
                   : int'($urandom_range(0, 4095)) - 2048;
  endtask

  initial begin
    // Reset dominates a high done_in.
    reset = 1'b0;
    done_in = 1'b1;
    tick();
    tick();
    chk_reset_outputs("reset");
    done_in = 1'b0;
    reset = 1'b1;

    // Ramp n*16, first edge after reset starts capture.
    for (int n = 0; n < K; n++) fr[n] = n * 16;
    run_frame(0, 0, -1);
    idle_gap();

    // Saturation at both ends.
    for (int n = 0; n < K; n++) fr[n] = 0;
    fr[5] = 32767;
    fr[6] = -32768;
    run_frame(0, 0, -1);
    idle_gap();

    // All equal: tie resolves to index 0, sticky overflow stays.
    for (int n = 0; n < K; n++) fr[n] = 100;
    run_frame(1, 0, -1);
    idle_gap();

    // Re-pulses during capture and drain are ignored.
    rand_fill();
    run_frame(2, 1, -1);
    idle_gap();

    // Reset at read index 10.
    rand_fill();
    run_frame(1, 1, 10);
    idle_gap();

    // Random frames with random backpressure.
    for (int f = 0; f < 6; f++) begin
      rand_fill();
      run_frame(2 + (f % 2), 0, -1);
      idle_gap();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
